// File: rtl/dir_key_pkg.sv
`default_nettype none
// ============================================================================
// dir_key_pkg : direction-key indices and per-key repeat FSM state type
// Revision    : 1.0
// ============================================================================
package dir_key_pkg;

   localparam int KEY_UP    = 0;
   localparam int KEY_DOWN  = 1;
   localparam int KEY_LEFT  = 2;
   localparam int KEY_RIGHT = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } key_state_t;

   // Partner key that cancels this one when both strobe together.
   function automatic int opposite_key(input int k);
      case (k)
         KEY_UP:    return KEY_DOWN;
         KEY_DOWN:  return KEY_UP;
         KEY_LEFT:  return KEY_RIGHT;
         KEY_RIGHT: return KEY_LEFT;
         default:   return k;
      endcase
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// key_debounce : 2-FF synchroniser plus stable-for-DEBOUNCE_CYC level filter
// Revision     : 1.0
// ============================================================================
module key_debounce #(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   localparam int            CW       = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;

   always_comb begin
      sync_d  = {sync_q[0], raw};
      level_d = level_q;
      cnt_d   = '0;
      // Count only consecutive cycles that disagree with the current level.
      if (sync_q[1] != level_q) begin
         if (cnt_q >= CNT_LAST) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level = level_q;

endmodule
`default_nettype wire

// File: rtl/dir_key_conditioner.sv
`default_nettype none
// ============================================================================
// dir_key_conditioner : debounced direction keys -> one-cycle move strobes;
//                       auto-repeat only when DIR_KEY_REPEAT_EN is defined
// Revision            : 1.0
// ============================================================================
module dir_key_conditioner
   import dir_key_pkg::*;
#(
   parameter int N_KEYS        = 4,
   parameter int DEBOUNCE_CYC  = 1_000_000,
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_raw,
   input  logic              draw_raw,
   output logic [N_KEYS-1:0] dir_level,
   output logic [N_KEYS-1:0] dir_pulse,
   output logic              draw
);

   if (DEBOUNCE_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("dir_key_conditioner: timing parameters must be at least 1");
   end

   logic [N_KEYS-1:0] key_level;
   logic [N_KEYS-1:0] strobe;
   logic [N_KEYS-1:0] dir_pulse_q, dir_pulse_d;
   key_state_t        state_q [N_KEYS];
   key_state_t        state_d [N_KEYS];

`ifdef DIR_KEY_REPEAT_EN
   localparam int            TW          = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);

   logic [TW-1:0] timer_q [N_KEYS];
   logic [TW-1:0] timer_d [N_KEYS];
`endif

   for (genvar k = 0; k < N_KEYS; k++) begin : g_key_db
      key_debounce #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_key_db (
         .clk   (clk),
         .rst   (rst),
         .raw   (key_raw[k]),
         .level (key_level[k])
      );
   end

   key_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_draw_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (draw_raw),
      .level (draw)
   );

   always_comb begin
      state_d = state_q;
      strobe  = '0;
`ifdef DIR_KEY_REPEAT_EN
      timer_d = timer_q;
`endif
      for (int k = 0; k < N_KEYS; k++) begin
         // Release wins over everything, including a timer expiring this cycle.
         if (!key_level[k]) begin
            state_d[k] = IDLE;
`ifdef DIR_KEY_REPEAT_EN
            timer_d[k] = '0;
`endif
         end else begin
            case (state_q[k])
               IDLE: begin
                  strobe[k]  = 1'b1;
                  state_d[k] = DELAY;
`ifdef DIR_KEY_REPEAT_EN
                  timer_d[k] = DELAY_LOAD;
`endif
               end
`ifdef DIR_KEY_REPEAT_EN
               DELAY, REPEAT: begin
                  if (timer_q[k] == '0) begin
                     strobe[k]  = 1'b1;
                     state_d[k] = REPEAT;
                     timer_d[k] = PERIOD_LOAD;
                  end else begin
                     timer_d[k] = timer_q[k] - TW'(1);
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

   // Simultaneous opposite strobes cancel; the FSMs above are unaffected.
   always_comb begin
      dir_pulse_d = strobe;
      for (int k = 0; k < N_KEYS; k++) begin
         if (opposite_key(k) != k && opposite_key(k) < N_KEYS) begin
            if (strobe[opposite_key(k)]) begin
               dir_pulse_d[k] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= '{default: IDLE};
         dir_pulse_q <= '0;
`ifdef DIR_KEY_REPEAT_EN
         timer_q     <= '{default: '0};
`endif
      end else begin
         state_q     <= state_d;
         dir_pulse_q <= dir_pulse_d;
`ifdef DIR_KEY_REPEAT_EN
         timer_q     <= timer_d;
`endif
      end
   end

   assign dir_level = key_level;
   assign dir_pulse = dir_pulse_q;

endmodule
`default_nettype wire
